ann_feature_buffer: RTL and testbench

//  Double-buffered (ping-pong) feature store that serves the ANN core's feature-read port.

---
 rtl/ann_feature_buffer.sv | 174 +++++++++++++++++
 tb/tb_ann_feature_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ann_feature_buffer.sv
// ann_feature_buffer
//   Ping-pong feature store sitting between feature extraction and the ANN
//   core. Upstream fills one bank with a window of FEAT_LEN words while the
//   ANN core reads the other, completed bank by address. When a bank becomes
//   full and the read side is idle, the block pulses oRun_ANN. The bank is
//   released when the ANN reports iFinish_Stage.
//
// Ports
//   iClk           clock, all logic on the rising edge
//   iReset         synchronous reset, active high
//   iWr_valid      upstream word valid
//   iWr_data       upstream word
//   oWr_ready      current write bank can take a word
//   iAddr_FBR      feature read address from the ANN core
//   oFeature       registered read data (1-cycle latency, 0 when out of range)
//   oRun_ANN       one-cycle start pulse to the ANN core
//   iFinish_Stage  ANN core is done with the current read bank
//   oBank_full     per-bank full flags, bit0 = bank0, bit1 = bank1
//   dbg_rd_state   read FSM state (0 = R_IDLE, 1 = R_RUN, 2 = R_BUSY)
//
// Handshake: a word transfers on a rising edge where iWr_valid and oWr_ready
// are both high. oWr_ready does not depend on iWr_valid. A word presented
// while oWr_ready is low is dropped, not held.

module ann_feature_buffer #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 7,
  parameter int FEAT_LEN = 100
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iWr_valid,
  input  logic [DATA_W-1:0] iWr_data,
  output logic              oWr_ready,
  input  logic [ADDR_W-1:0] iAddr_FBR,
  output logic [DATA_W-1:0] oFeature,
  output logic              oRun_ANN,
  input  logic              iFinish_Stage,
  output logic [1:0]        oBank_full,
  output logic [1:0]        dbg_rd_state
);

  // Both banks live in one array: bank0 at [0, FEAT_LEN), bank1 above it.
  localparam int DEPTH = 2 * FEAT_LEN;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RUN  = 2'd1,
    R_BUSY = 2'd2
  } rd_state_t;

  rd_state_t         state_q;
  rd_state_t         state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_bank;
  logic [ADDR_W-1:0] wr_cnt;
  logic              rd_bank;

  logic              wr_acc;
  logic              wr_last;
  logic              rd_release;
  logic              addr_ok;
  logic [1:0]        set_mask;
  logic [1:0]        clr_mask;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  // ---------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------
  assign oWr_ready = ~oBank_full[wr_bank];
  assign wr_acc    = iWr_valid & oWr_ready;
  assign wr_last   = (int'(wr_cnt) == FEAT_LEN - 1);

  // wr_cnt never exceeds FEAT_LEN-1, so the narrowing cast keeps the value.
  assign wr_idx = wr_bank ? (IDX_W'(FEAT_LEN) + IDX_W'(wr_cnt)) : IDX_W'(wr_cnt);

  always_ff @(posedge iClk) begin
    if (wr_acc) begin
      mem[wr_idx] <= iWr_data;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (wr_acc) begin
      if (wr_last) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt <= wr_cnt + ADDR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Full flags. A completing write and a read release always hit different
  // banks (the bank being read is full, so it cannot be written), so both
  // updates are applied together without priority concerns.
  // ---------------------------------------------------------------------
  always_comb begin
    set_mask = 2'b00;
    clr_mask = 2'b00;
    if (wr_acc && wr_last) begin
      set_mask[wr_bank] = 1'b1;
    end
    if (rd_release) begin
      clr_mask[rd_bank] = 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      oBank_full <= 2'b00;
    end else begin
      oBank_full <= (oBank_full | set_mask) & ~clr_mask;
    end
  end

  // ---------------------------------------------------------------------
  // Read data, one-cycle latency, open in every FSM state.
  // ---------------------------------------------------------------------
  assign addr_ok = (int'(iAddr_FBR) < FEAT_LEN);
  // Only used when addr_ok, so the narrowing cast keeps the value.
  assign rd_idx  = rd_bank ? (IDX_W'(FEAT_LEN) + IDX_W'(iAddr_FBR)) : IDX_W'(iAddr_FBR);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      oFeature <= '0;
    end else if (addr_ok) begin
      oFeature <= mem[rd_idx];
    end else begin
      oFeature <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------
  assign rd_release = (state_q == R_BUSY) && iFinish_Stage;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= R_IDLE;
      rd_bank <= 1'b0;
    end else begin
      state_q <= state_d;
      if (rd_release) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:  if (oBank_full[rd_bank]) state_d = R_RUN;
      R_RUN:   state_d = R_BUSY;
      R_BUSY:  if (iFinish_Stage) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    oRun_ANN     = (state_q == R_RUN);
    dbg_rd_state = state_q;
  end

endmodule

// File: tb/tb_ann_feature_buffer.sv
// tb_ann_feature_buffer
//   Directed bench for ann_feature_buffer. One instance uses FEAT_LEN=100,
//   a second uses FEAT_LEN=4 for the short-window scoreboard test. Inputs
//   are driven and outputs sampled on the falling clock edge.

module tb_ann_feature_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (FEAT_LEN = 100)
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data  = '0;
  logic              wr_ready;
  logic [ADDR_W-1:0] addr     = '0;
  logic [DATA_W-1:0] feature;
  logic              run_ann;
  logic              finish   = 1'b0;
  logic [1:0]        bank_full;
  logic [1:0]        rd_state;

  // Short-window instance (FEAT_LEN = 4)
  logic              w4_valid = 1'b0;
  logic [DATA_W-1:0] w4_data  = '0;
  logic              w4_ready;
  logic [ADDR_W-1:0] a4       = '0;
  logic [DATA_W-1:0] f4;
  logic              run4;
  logic              fin4     = 1'b0;
  logic [1:0]        full4;
  logic [1:0]        st4;

  ann_feature_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FEAT_LEN(100)) dut (
    .iClk(clk), .iReset(rst),
    .iWr_valid(wr_valid), .iWr_data(wr_data), .oWr_ready(wr_ready),
    .iAddr_FBR(addr), .oFeature(feature), .oRun_ANN(run_ann),
    .iFinish_Stage(finish), .oBank_full(bank_full), .dbg_rd_state(rd_state)
  );

  ann_feature_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FEAT_LEN(4)) dut4 (
    .iClk(clk), .iReset(rst),
    .iWr_valid(w4_valid), .iWr_data(w4_data), .oWr_ready(w4_ready),
    .iAddr_FBR(a4), .oFeature(f4), .oRun_ANN(run4),
    .iFinish_Stage(fin4), .oBank_full(full4), .dbg_rd_state(st4)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks (entered and left just after a falling edge)
  // ---------------------------------------------------------------------
  task automatic write_seq(input string tag, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, wr_ready, 1);
      wr_valid = 1'b1;
      wr_data  = DATA_W'(base + i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int a, input int exp);
    addr = ADDR_W'(a);
    @(negedge clk);
    check(tag, feature, exp);
  endtask

  task automatic send4(input string tag);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 4; i++) begin
      w4_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check(tag, w4_ready, 1);
      d        = DATA_W'($urandom);
      w4_valid = 1'b1;
      w4_data  = d;
      if (w4_ready) exp_q.push_back(d);
      @(negedge clk);
    end
    w4_valid = 1'b0;
  endtask

  task automatic drain4(input string tag);
    logic [DATA_W-1:0] e;
    int n = 0;
    while (st4 != 2'd2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy"}, st4, 2);
    for (int a = 0; a < 4; a++) begin
      a4 = ADDR_W'(a);
      @(negedge clk);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check(tag, f4, e);
    end
    fin4 = 1'b1;
    @(negedge clk);
    fin4 = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_full",    bank_full, 0);
    check("rst_run",     run_ann,   0);
    check("rst_feature", feature,   0);
    check("rst_ready",   wr_ready,  1);
    check("rst_state",   rd_state,  0);

    // 1: fill bank0 with 0..99
    write_seq("t1_ready", 0, 100);
    check("t1_full",      bank_full, 1);
    check("t1_run_n0",    run_ann,   0);
    @(negedge clk);
    check("t1_run_n1",    run_ann,   1);
    @(negedge clk);
    check("t1_run_n2",    run_ann,   0);
    check("t1_busy",      rd_state,  2);

    // 2: reads of bank0
    read_chk("t2_addr5",   5,   5);
    read_chk("t2_addr99",  99,  99);
    read_chk("t2_addr120", 120, 0);

    // 3: fill bank1 while busy, then release bank0
    write_seq("t3_ready", 1000, 100);
    check("t3_full11",  bank_full, 3);
    check("t3_block",   wr_ready,  0);
    wr_valid = 1'b1;
    wr_data  = 32'd7777;
    repeat (3) @(negedge clk);
    wr_valid = 1'b0;
    check("t3_drop_full", bank_full, 3);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("t3_full10",  bank_full, 2);
    check("t3_ready_up", wr_ready, 1);
    check("t3_run_n0",  run_ann,   0);
    @(negedge clk);
    check("t3_run_n1",  run_ann,   1);
    read_chk("t3_addr0",  0,  1000);
    read_chk("t3_addr99", 99, 1099);
    check("t3_run_once", run_ann, 0);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("t3_full00",  bank_full, 0);

    // 4: stray finish while idle with nothing full
    finish = 1'b1;
    @(negedge clk);
    @(negedge clk);
    finish = 1'b0;
    check("t4_full",  bank_full, 0);
    check("t4_run",   run_ann,   0);
    check("t4_state", rd_state,  0);
    read_chk("t4_bank0", 3, 3);

    // 5: partial window discarded by reset
    write_seq("t5_ready_a", 500, 50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_full",    bank_full, 0);
    check("t5_rst_feature", feature,   0);
    write_seq("t5_ready_b", 200, 100);
    check("t5_full",   bank_full, 1);
    @(negedge clk);
    check("t5_run_n1", run_ann,   1);
    @(negedge clk);
    check("t5_run_n2", run_ann,   0);
    read_chk("t5_addr0",  0,  200);
    read_chk("t5_addr49", 49, 249);
    read_chk("t5_addr50", 50, 250);
    check("t5_run_quiet", run_ann, 0);

    // 6: FEAT_LEN=4, three windows with random valid gaps
    send4("t6_ready_a");
    send4("t6_ready_b");
    check("t6_full11", full4,    3);
    check("t6_block",  w4_ready, 0);
    w4_valid = 1'b1;
    w4_data  = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    w4_valid = 1'b0;
    drain4("t6_win_a");
    send4("t6_ready_c");
    drain4("t6_win_b");
    drain4("t6_win_c");
    check("t6_left",  exp_q.size(), 0);
    check("t6_empty", full4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
